// File: rtl/iq_ring_queue.sv
// iq_ring_queue
// Instruction queue sitting between fetch/align and decode. Each accepted fetch
// bundle contributes up to FETCH_W {pc, instr} slots. The last valid slot of a
// bundle carries the predicted jump target, and every other slot carries a zero
// target. Entries live in a DEPTH-entry circular buffer, and up to ISSUE_W of
// the oldest entries are presented to decode every cycle.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous reset, active low
//   i_flush         discard all entries; drops same-cycle enqueue/dequeue
//   i_fetch_valid   fetch bundle present
//   o_fetch_ready   room for a full FETCH_W bundle (registered state only)
//   i_fetch_bundle  slot k at [k*64+:64] = {pc, instr}
//   i_fetch_last    index of the last valid slot (count = last + 1)
//   i_got_jump      last valid slot is a predicted-taken branch
//   i_jump_addr     predicted target for that slot
//   o_issue_valid   issue bundle valid
//   i_issue_ready   decode accepts the bundle
//   o_issue_bundle  entry j at [j*96+:96] = {target, pc, instr}, oldest at j=0
//   o_issue_count   number of real (non-NOP) entries in the bundle
//   o_num           occupied entries
//   o_room          free entries (DEPTH - o_num)
module iq_ring_queue #(
    parameter int          DEPTH         = 16,
    parameter int          FETCH_W       = 8,
    parameter int          ISSUE_W       = 4,
    parameter int          PARTIAL_ISSUE = 1,
    parameter logic [31:0] NOP_INSTR     = 32'h0000_0013,
    localparam int         LAST_W        = (FETCH_W > 1) ? $clog2(FETCH_W) : 1,
    localparam int         CNT_W         = $clog2(ISSUE_W + 1),
    localparam int         NUM_W         = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_fetch_valid,
    output logic                    o_fetch_ready,
    input  logic [64*FETCH_W-1:0]   i_fetch_bundle,
    input  logic [LAST_W-1:0]       i_fetch_last,
    input  logic                    i_got_jump,
    input  logic [31:0]             i_jump_addr,
    output logic                    o_issue_valid,
    input  logic                    i_issue_ready,
    output logic [96*ISSUE_W-1:0]   o_issue_bundle,
    output logic [CNT_W-1:0]        o_issue_count,
    output logic [NUM_W-1:0]        o_num,
    output logic [NUM_W-1:0]        o_room
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = NUM_W + 1;

    logic [95:0]      ring [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [NUM_W-1:0] num;

    logic             enq_fire;
    logic             deq_fire;
    logic [NUM_W-1:0] enq_cnt;
    logic [NUM_W-1:0] deq_cnt;

    // The offset never exceeds DEPTH, so one conditional subtract is enough
    // for the wrap. This also works when DEPTH is not a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                                 input logic [NUM_W-1:0] n);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(ptr) + SUM_W'(n);
        if (sum >= SUM_W'(DEPTH))
            sum = sum - SUM_W'(DEPTH);
        return sum[PTR_W-1:0];
    endfunction

    assign o_num         = num;
    assign o_room        = NUM_W'(DEPTH) - num;
    // Fetch readiness uses pre-dequeue room only. There is no path from
    // i_issue_ready to o_fetch_ready.
    assign o_fetch_ready = (o_room >= NUM_W'(FETCH_W));

    assign o_issue_count = (num >= NUM_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : CNT_W'(num);
    assign o_issue_valid = (PARTIAL_ISSUE != 0) ? (num != '0)
                                                : (num >= NUM_W'(ISSUE_W));

    assign enq_fire = i_fetch_valid & o_fetch_ready & ~i_flush;
    assign deq_fire = o_issue_valid & i_issue_ready & ~i_flush;
    assign enq_cnt  = enq_fire ? (NUM_W'(i_fetch_last) + NUM_W'(1)) : '0;
    assign deq_cnt  = deq_fire ? NUM_W'(o_issue_count) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            num  <= '0;
        end else if (i_flush) begin
            head <= '0;
            tail <= '0;
            num  <= '0;
        end else begin
            head <= ptr_add(head, deq_cnt);
            tail <= ptr_add(tail, enq_cnt);
            num  <= num + enq_cnt - deq_cnt;
        end
    end

    // The entry array holds no reset. Contents are only read once occupancy
    // covers them.
    always_ff @(posedge clk) begin
        if (rst && enq_fire) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (LAST_W'(k) <= i_fetch_last) begin
                    ring[ptr_add(tail, NUM_W'(k))] <=
                        {((i_got_jump && (LAST_W'(k) == i_fetch_last)) ? i_jump_addr : 32'h0),
                         i_fetch_bundle[k*64 +: 64]};
                end
            end
        end
    end

    // Issue view is combinational from registered state. An entry enqueued
    // this cycle becomes visible on the next cycle.
    always_comb begin
        o_issue_bundle = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            if (CNT_W'(j) < o_issue_count)
                o_issue_bundle[j*96 +: 96] = ring[ptr_add(head, NUM_W'(j))];
            else
                o_issue_bundle[j*96 +: 96] = {64'h0, NOP_INSTR};
        end
    end

endmodule
